// File: rtl/md_unit.sv
// md_unit: iterative RV32M multiply/divide unit with fixed 34-cycle latency
module md_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            done,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   am, bm;
  logic              neg_a, neg_p, bz;
  logic [2*XLEN-1:0] p, nxt, prod;
  logic [4:0]        cnt;
  logic              a_s, b_s;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem, res;
  logic [XLEN:0]     sum, sh, diff;
  assign busy = state != IDLE;
  // Operand signedness and magnitudes at issue time
  always_comb begin
    a_s   = rs1_val[XLEN-1] & (op == 3'd1 || op == 3'd2 || (op[2] && !op[0]));
    b_s   = rs2_val[XLEN-1] & (op == 3'd1 || (op[2] && !op[0]));
    a_mag = a_s ? -rs1_val : rs1_val;
    b_mag = b_s ? -rs2_val : rs2_val;
  end
  // One iteration: shift-add multiply (p = {acc, multiplier}) or restoring divide (p = {rem, quo})
  always_comb begin
    sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, am} : '0);
    sh   = p[2*XLEN-1:XLEN-1];
    diff = sh - {1'b0, bm};
    nxt  = !op_r[2] ? {sum, p[XLEN-1:1]} :
           diff[XLEN] ? {sh[XLEN-1:0], p[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
  end
  // Sign correction and result selection used on the FIX edge
  always_comb begin
    prod = neg_p ? -p : p;
    quo  = bz ? '1 : (neg_p ? -p[XLEN-1:0] : p[XLEN-1:0]);
    rem  = neg_a ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    res  = op_r == 3'd0 ? prod[XLEN-1:0] : !op_r[2] ? prod[2*XLEN-1:XLEN] : !op_r[1] ? quo : rem;
  end
  // Control FSM with registered done and write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      wb_data <= '0;
      wb_rd   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r  <= op;
          am    <= a_mag;
          bm    <= b_mag;
          neg_a <= a_s;
          neg_p <= a_s ^ b_s;
          bz    <= rs2_val == '0;
          wb_rd <= rd;
          cnt   <= '0;
          p     <= {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
          state <= CALC;
        end
        CALC: begin
          p     <= nxt;
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? FIX : CALC;
        end
        FIX: begin
          wb_data <= res;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit
module tb_md_unit;
  logic        clk = 0, rst = 1, start = 0;
  logic [2:0]  op = 0;
  logic [31:0] rs1_val = 0, rs2_val = 0;
  logic [4:0]  rd = 0;
  logic        busy, done;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int errors = 0, checks = 0;

  md_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd(rd), .busy(busy), .done(done), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; rd = r; start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done && n < 100);
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd); end
    rst = 0;
  endtask

  task automatic test_arith;
    logic [2:0]  ops [16] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5,
                              3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0, 3'd4};
    logic [31:0] as  [16] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd5, 32'hFFFFFFF9, 32'h80000000, 32'h80000000, 32'h0, 32'd0};
    logic [31:0] bs  [16] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'd9};
    logic [31:0] exp [16] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'd100,
                              32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h0, 32'h0, 32'h0};
    int n;
    for (int i = 0; i < 16; i++) begin
      start_op(ops[i], as[i], bs[i], 5'(i + 1));
      wait_done(n);
      checks++; if (n !== 33) begin errors++; $display("FAIL arith%0d_latency got=%0d exp=33", i, n); end
      checks++; if (wb_data !== exp[i]) begin errors++; $display("FAIL arith%0d_data op=%0d got=%h exp=%h", i, ops[i], wb_data, exp[i]); end
      checks++; if (wb_rd !== 5'(i + 1)) begin errors++; $display("FAIL arith%0d_rd got=%0d exp=%0d", i, wb_rd, i + 1); end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arith%0d_after got done=%b busy=%b exp 0 0", i, done, busy); end
    end
  endtask

  task automatic test_busy_ignore;
    int n;
    start_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = 3'd4; rs1_val = 32'h12345678; rs2_val = 32'd1; rd = 5'd9; start = 1;
    @(posedge clk);
    #1 start = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    wait_done(n);
    checks++; if (n !== 27) begin errors++; $display("FAIL ignore_latency got=%0d exp=27", n); end
    checks++; if (wb_data !== 32'hFFFFFFEB) begin errors++; $display("FAIL ignore_data got=%h exp=FFFFFFEB", wb_data); end
    checks++; if (wb_rd !== 5'd3) begin errors++; $display("FAIL ignore_rd got=%0d exp=3", wb_rd); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_restart got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_back_to_back;
    int n;
    start_op(3'd5, 32'hFFFFFFF9, 32'd2, 5'd5);
    wait_done(n);
    checks++; if (n !== 33 || wb_data !== 32'h7FFFFFFC || wb_rd !== 5'd5) begin errors++; $display("FAIL b2b_first got lat=%0d data=%h rd=%0d exp 33 7FFFFFFC 5", n, wb_data, wb_rd); end
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    start_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    wait_done(n);
    checks++; if (n !== 33 || wb_data !== 32'hFFFFFFFE || wb_rd !== 5'd6) begin errors++; $display("FAIL b2b_second got lat=%0d data=%h rd=%0d exp 33 FFFFFFFE 6", n, wb_data, wb_rd); end
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int n, seen;
    start_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd4);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1; start = 1; op = 3'd0; rs1_val = 32'd9; rs2_val = 32'd9; rd = 5'd8;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rstmid_data got=%h exp=0", wb_data); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rstmid_rd got=%0d exp=0", wb_rd); end
    rst = 0; start = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d active cycles exp=0", seen); end
    start_op(3'd0, 32'd3, 32'd4, 5'd7);
    wait_done(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL rstmid_mul_latency got=%0d exp=33", n); end
    checks++; if (wb_data !== 32'd12 || wb_rd !== 5'd7) begin errors++; $display("FAIL rstmid_mul got data=%h rd=%0d exp 0000000c 7", wb_data, wb_rd); end
    @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_arith;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
